// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX serializer
// between NUM_REQ byte producers. Each accepted byte is launched with a
// one-cycle tx_data_valid pulse. The arbiter then follows tx_busy, and it
// drops the byte if the serializer never starts.
// Optional feature: define UART_ARB_LOCK_EN to let a requester hold its grant
// across several bytes with req_lock.
module uart_tx_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int BUSY_TO = 16,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_p_data,
  output logic                 tx_data_valid,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       gnt_id,
  output logic                 gnt_active,
  output logic                 busy_timeout
);

  // The counter only has to reach BUSY_TO-2. The timeout fires on the edge
  // where the count would become BUSY_TO-1.
  localparam int CW = (BUSY_TO > 2) ? $clog2(BUSY_TO - 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     tx_p_data_q, tx_p_data_d;
  logic           tx_data_valid_q, tx_data_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_active_q, gnt_active_d;
  logic           busy_timeout_q, busy_timeout_d;
  logic [IDW-1:0] last_gnt_q, last_gnt_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   sum;

`ifdef UART_ARB_LOCK_EN
  logic           lock_q, lock_d;
`else
  logic           unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Pick the first valid requester after last_gnt, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_gnt_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
`ifdef UART_ARB_LOCK_EN
    // A locked grant only lets the current owner back in.
    if (lock_q) begin
      found = req_valid[gnt_id_q];
      win   = gnt_id_q;
    end
`endif
  end

  // Next-state logic and the ready strobe. Ready is raised only in IDLE, and
  // only while no frame from any source is on the line.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tx_p_data_d     = tx_p_data_q;
    tx_data_valid_d = 1'b0;
    gnt_id_d        = gnt_id_q;
    gnt_active_d    = gnt_active_q;
    busy_timeout_d  = 1'b0;
    last_gnt_d      = last_gnt_q;
    req_ready       = '0;
`ifdef UART_ARB_LOCK_EN
    lock_d          = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (rst && found && !tx_busy) begin
          req_ready[win]  = 1'b1;
          tx_p_data_d     = req_data[8*win +: 8];
          gnt_id_d        = win;
          gnt_active_d    = 1'b1;
          tx_data_valid_d = 1'b1;
          state_d         = LAUNCH;
`ifdef UART_ARB_LOCK_EN
          lock_d          = req_lock[win];
`endif
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TO - 2)) begin
          // The serializer never started: drop the byte and free the line.
          busy_timeout_d = 1'b1;
          gnt_active_d   = 1'b0;
          last_gnt_d     = gnt_id_q;
          state_d        = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d         = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gnt_active_d = 1'b0;
          last_gnt_d   = gnt_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. last_gnt resets to NUM_REQ-1 so that
  // requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      gnt_id_q        <= '0;
      gnt_active_q    <= 1'b0;
      busy_timeout_q  <= 1'b0;
      last_gnt_q      <= IDW'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_q          <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tx_p_data_q     <= tx_p_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      gnt_id_q        <= gnt_id_d;
      gnt_active_q    <= gnt_active_d;
      busy_timeout_q  <= busy_timeout_d;
      last_gnt_q      <= last_gnt_d;
`ifdef UART_ARB_LOCK_EN
      lock_q          <= lock_d;
`endif
    end
  end

  assign tx_p_data     = tx_p_data_q;
  assign tx_data_valid = tx_data_valid_q;
  assign gnt_id        = gnt_id_q;
  assign gnt_active    = gnt_active_q;
  assign busy_timeout  = busy_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. The stimulus pushes the expected (byte, grant)
// pairs. A monitor pops and compares them on every tx_data_valid pulse. A
// small TX model raises tx_busy after each launch unless never_busy is set.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_p_data;
  logic           tx_data_valid;
  logic           tx_busy;
  logic [1:0]     gnt_id;
  logic           gnt_active;
  logic           busy_timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TO(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .gnt_id(gnt_id),
    .gnt_active(gnt_active), .busy_timeout(busy_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic [1:0] id;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] src_d[N][$];
  logic       src_l[N][$];
  int         tests = 0;
  int         fails = 0;
  int         rdy_cnt = 0;
  logic       never_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Serializer model: busy rises 2 cycles after the launch pulse and lasts 9 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_data_valid === 1'b1 && !never_busy) begin
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (9) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the oldest expected entry and must not overlap a frame.
  always @(negedge clk) begin
    if (tx_data_valid === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got byte 0x%0h id %0d, expected no launch", tx_p_data, gnt_id);
      end else begin
        e = exp_q.pop_front();
        chk("sb_launch", {22'd0, tx_p_data, gnt_id}, {22'd0, e.data, e.id});
      end
      chk("no_launch_while_busy", {31'd0, tx_busy}, 32'd0);
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_d[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Presents the queue heads each cycle and pops the one that handshakes.
  task automatic run(input int budget);
    int cyc = 0;
    int acc;
    while (cyc < budget && !all_empty()) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = (src_d[i].size() > 0);
        req_data[8*i +: 8] = req_valid[i] ? src_d[i][0] : 8'h00;
        req_lock[i]        = req_valid[i] ? src_l[i][0] : 1'b0;
      end
      #1;
      acc = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) begin acc = i; rdy_cnt++; end
      @(posedge clk); #1;
      if (acc >= 0) begin
        void'(src_d[acc].pop_front());
        void'(src_l[acc].pop_front());
      end
      cyc++;
    end
    req_valid = '0;
    if (!all_empty()) begin
      tests++; fails++;
      $display("FAIL run_timeout: got pending bytes after %0d cycles, expected none", budget);
    end
  endtask

  task automatic add(input int r, input logic [7:0] d, input logic l);
    src_d[r].push_back(d);
    src_l[r].push_back(l);
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] id);
    exp_t e;
    e.data = d; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int c = 0;
    while (tx_busy !== lvl && c < 40) begin @(negedge clk); c++; end
    chk(nm, {31'd0, tx_busy}, {31'd0, lvl});
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((gnt_active || tx_busy || tx_data_valid) && c < 100) begin @(posedge clk); #1; c++; end
    chk("wait_idle", {30'd0, gnt_active, tx_busy}, 32'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {18'd0, tx_p_data, gnt_id, gnt_active, tx_data_valid, busy_timeout},
        32'd0);
    chk("reset_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    int cyc;
    // 1: single byte from requester 0
    do_reset();
    expect_tx(8'hA5, 2'd0);
    add(0, 8'hA5, 1'b0);
    rdy_cnt = 0;
    run(50);
    chk("t1_ready_cycles", rdy_cnt, 32'd1);
    chk("t1_active_launch", {31'd0, gnt_active}, 32'd1);
    wait_busy(1'b1, "t1_busy_rise");
    wait_busy(1'b0, "t1_busy_fall");
    chk("t1_active_during_last", {31'd0, gnt_active}, 32'd1);
    @(posedge clk); #1;
    chk("t1_active_drop", {31'd0, gnt_active}, 32'd0);
    chk("t1_data_hold", {24'd0, tx_p_data}, 32'h0000_00A5);

    // 2: all four requesters with two bytes each, fresh priority
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) begin
        add(i, 8'(8'h10 * (i + 1) + j), 1'b0);
        expect_tx(8'(8'h10 * (i + 1) + j), 2'(i));
      end
    run(400);
    wait_idle();

    // 3: last served = 2, requesters 0 and 3 valid -> 3 then 0
    add(2, 8'h33, 1'b0); expect_tx(8'h33, 2'd2);
    run(100); wait_idle();
    add(0, 8'h40, 1'b0); add(3, 8'h43, 1'b0);
    expect_tx(8'h43, 2'd3); expect_tx(8'h40, 2'd0);
    run(200); wait_idle();

    // 4: serializer never starts -> timeout 16 cycles after LAUNCH, byte dropped
    never_busy = 1'b1;
    add(1, 8'h5A, 1'b0); expect_tx(8'h5A, 2'd1);
    run(50);
    cyc = 0;
    while (!busy_timeout && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("t4_timeout_latency", cyc, 32'd16);
    chk("t4_active_cleared", {31'd0, gnt_active}, 32'd0);
    @(posedge clk); #1;
    chk("t4_pulse_width", {31'd0, busy_timeout}, 32'd0);
    never_busy = 1'b0;
    add(2, 8'h77, 1'b0); expect_tx(8'h77, 2'd2);
    run(100); wait_idle();

    // 5: asynchronous reset during WAIT_DONE, then blocked by the stale frame
    add(3, 8'h99, 1'b0); expect_tx(8'h99, 2'd3);
    run(100);
    wait_busy(1'b1, "t5_busy_rise");
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t5_async_reset", {18'd0, tx_p_data, gnt_id, gnt_active, tx_data_valid, busy_timeout},
        32'd0);
    @(negedge clk) rst = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("t5_blocked_by_busy", {28'd0, req_ready}, 32'd0);
    add(0, 8'hC0, 1'b0); add(3, 8'hC3, 1'b0);
    expect_tx(8'hC0, 2'd0); expect_tx(8'hC3, 2'd3);
    run(200); wait_idle();

    // 6: three-byte message from requester 0 with lock = 1,1,0 while requester 1 is waiting
    do_reset();
    add(0, 8'hB0, 1'b1); add(0, 8'hB1, 1'b1); add(0, 8'hB2, 1'b0);
    add(1, 8'hD1, 1'b0); add(1, 8'hD2, 1'b0);
`ifdef UART_ARB_LOCK_EN
    expect_tx(8'hB0, 2'd0); expect_tx(8'hB1, 2'd0); expect_tx(8'hB2, 2'd0);
    expect_tx(8'hD1, 2'd1); expect_tx(8'hD2, 2'd1);
`else
    expect_tx(8'hB0, 2'd0); expect_tx(8'hD1, 2'd1); expect_tx(8'hB1, 2'd0);
    expect_tx(8'hD2, 2'd1); expect_tx(8'hB2, 2'd0);
`endif
    run(300); wait_idle();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier");
    $fatal(1);
  end
endmodule
